cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common-data-bus scheduler for the out-of-order core. ALU, load/store buffer and reorder buffer each produce result broadcasts (tag + 32-bit value). This block merges them onto one registered bus that every tag-matching consumer snoops. Each producer has a small private queue, results are granted round-robin, producers are back-pressured with a ready signal, and everything in flight is flushed on rollback.

## Interface
- TAG_WIDTH, 4: ROB tag width.
- DATA_WIDTH, 32: result width.
- FIFO_DEPTH, 2: entries per source queue; power of two, ≥2.

- clk  input  1  core clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- rollback_in  input  1  misprediction flush from ROB.
- alu_valid_in  input  1  ALU result present this cycle.
- alu_result_in  input  DATA_WIDTH  ALU result.
- alu_tag_in  input  TAG_WIDTH  ALU destination tag.
- alu_ready_out  output  1  ALU queue can accept (count < FIFO_DEPTH).
- lsb_valid_in / lsb_result_in / lsb_tag_in  input  1 / DATA_WIDTH / TAG_WIDTH  LSB result.
- lsb_ready_out  output  1  LSB queue can accept.
- rob_valid_in / rob_result_in / rob_tag_in  input  1 / DATA_WIDTH / TAG_WIDTH  ROB re-broadcast.
- rob_ready_out  output  1  ROB queue can accept.
- cdb_valid_out  output  1  bus carries a result this cycle.
- cdb_result_out  output  DATA_WIDTH  broadcast value.
- cdb_tag_out  output  TAG_WIDTH  broadcast tag.
- cdb_src_out  output  2  granted source: 0 ALU, 1 LSB, 2 ROB.

## Operation
- Sources are indexed 0 ALU, 1 LSB, 2 ROB. Each source has a circular FIFO with head, tail and count registers. Head and tail wrap modulo FIFO_DEPTH.
- Push happens when valid_in=1 and count<FIFO_DEPTH. Valid_in while full is dropped; producers must honour ready_out.
- Each cycle the requesters are the sources with count>0. When the bypass option is compiled in, a source is also a requester when its FIFO is empty and valid_in=1.
- Arbitration is round-robin:
  - rr_ptr is 2 bits and resets to 0.
  - Search order is rr_ptr, rr_ptr+1, rr_ptr+2, all mod 3.
  - The first requester found wins.
  - On a grant to source s, rr_ptr becomes (s+1) mod 3. With no grant, rr_ptr holds.
- The winner's head entry (or its bypassed input) is loaded into the output registers and cdb_valid_out is set to 1. With no winner, cdb_valid_out is set to 0; result, tag and src hold their previous values.
- Push and pop on the same FIFO in the same cycle leave count unchanged. This is legal even when the FIFO is full, because ready_out is based on the registered count.
- Rollback (synchronous, sampled on the edge):
  - All counts, heads and tails are cleared.
  - Inputs presented in the rollback cycle are discarded.
  - cdb_valid_out is 0 on the next cycle.
  - rr_ptr is reset to 0.
- Reset (asynchronous): all queues are empty, rr_ptr=0, every cdb_*_out is 0, and every *_ready_out is 1.
- Broadcasts are never reordered within one source.

## Timing
- ready_out is a function of registered count only; it never depends combinationally on valid_in.
- Latency from valid_in to cdb_valid_out:
  - Through the queue: 2 cycles minimum (push at edge N+1, grant at edge N+2).
  - With bypass on an empty queue: 1 cycle.
- Throughput is one broadcast per cycle in total.
- Under saturation each source gets at least 1 grant in every 3 cycles.
- Rollback in the same cycle as a grant: the grant is cancelled and cdb_valid_out is 0 next cycle.
- Rollback overrides push and pop in the same cycle.

## Configuration
- CDB_BYPASS_EN defined:
  - An empty source queue with valid_in competes in arbitration that same cycle.
  - If it wins, the input goes straight to the output registers (1-cycle latency) and is not enqueued.
  - If it loses, it is enqueued normally.
- CDB_BYPASS_EN undefined: every result is enqueued first; minimum latency is 2 cycles. The bypass muxes are absent.

## Test plan
- Reset mid-traffic: assert rst with 2 entries queued in ALU → asynchronously cdb_valid_out=0, all ready_out=1; next grant goes to ALU (rr_ptr=0).
- Single ALU result 0x0000_0042, tag 3, empty queues:
  - With CDB_BYPASS_EN → cdb_valid_out=1, tag 3, src 0 one cycle later.
  - Without it → same result two cycles later.
- All three sources valid every cycle for 9 cycles, DEPTH=2 → cdb_src_out sequence 0,1,2,0,1,2,…; ready_out deasserts when count=2; no result is lost or reordered per source.
- LSB pushes tags 5,6 back-to-back while ROB holds the grant → LSB queue full, lsb_ready_out=0; after the two pops, tags appear in order 5 then 6.
- rollback_in pulse with 4 entries queued across sources → next cycle cdb_valid_out=0, all queues empty, no old tag appears afterwards.
- Push and pop on a full ALU queue in the same cycle → count stays 2, ready stays 0, FIFO order is preserved across head/tail wrap.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus scheduler: three per-source result FIFOs merged round-robin onto one registered bus.
// Optional same-cycle bypass of an empty queue is compiled in with CDB_BYPASS_EN.
module cdb_arbiter #(
    parameter int TAG_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rollback_in,
    input  logic                  alu_valid_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [TAG_WIDTH-1:0]  alu_tag_in,
    output logic                  alu_ready_out,
    input  logic                  lsb_valid_in,
    input  logic [DATA_WIDTH-1:0] lsb_result_in,
    input  logic [TAG_WIDTH-1:0]  lsb_tag_in,
    output logic                  lsb_ready_out,
    input  logic                  rob_valid_in,
    input  logic [DATA_WIDTH-1:0] rob_result_in,
    input  logic [TAG_WIDTH-1:0]  rob_tag_in,
    output logic                  rob_ready_out,
    output logic                  cdb_valid_out,
    output logic [DATA_WIDTH-1:0] cdb_result_out,
    output logic [TAG_WIDTH-1:0]  cdb_tag_out,
    output logic [1:0]            cdb_src_out
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [2:0]            vld_in;
    logic [DATA_WIDTH-1:0] res_in [3];
    logic [TAG_WIDTH-1:0]  tag_in [3];

    logic [PW-1:0]         head_q [3];
    logic [PW-1:0]         head_d [3];
    logic [PW-1:0]         tail_q [3];
    logic [PW-1:0]         tail_d [3];
    logic [CW-1:0]         cnt_q  [3];
    logic [CW-1:0]         cnt_d  [3];
    logic [DATA_WIDTH-1:0] res_mem_q [3][FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem_q [3][FIFO_DEPTH];

    logic [1:0]            rr_q, rr_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [1:0]            src_q, src_d;

    logic [2:0]            req, push, pop;
    logic                  grant;
    logic [1:0]            gsel;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign vld_in    = {rob_valid_in, lsb_valid_in, alu_valid_in};
    assign res_in[0] = alu_result_in;
    assign res_in[1] = lsb_result_in;
    assign res_in[2] = rob_result_in;
    assign tag_in[0] = alu_tag_in;
    assign tag_in[1] = lsb_tag_in;
    assign tag_in[2] = rob_tag_in;

    // Ready comes only from the registered count, never from valid_in.
    assign alu_ready_out  = (cnt_q[0] != FULL);
    assign lsb_ready_out  = (cnt_q[1] != FULL);
    assign rob_ready_out  = (cnt_q[2] != FULL);
    assign cdb_valid_out  = valid_q;
    assign cdb_result_out = result_q;
    assign cdb_tag_out    = tag_q;
    assign cdb_src_out    = src_q;

    always_comb begin : arbitrate
        logic [1:0] idx;
        req = '0;
        for (int s = 0; s < 3; s++) begin
`ifdef CDB_BYPASS_EN
            req[s] = (cnt_q[s] != '0) || vld_in[s];
`else
            req[s] = (cnt_q[s] != '0);
`endif
        end
        grant = 1'b0;
        gsel  = 2'd0;
        idx   = rr_q;
        for (int k = 0; k < 3; k++) begin
            if (!grant && req[idx]) begin
                grant = 1'b1;
                gsel  = idx;
            end
            idx = inc3(idx);
        end
    end

    always_comb begin : next_state
        rr_d     = rr_q;
        valid_d  = grant;
        result_d = result_q;
        tag_d    = tag_q;
        src_d    = src_q;
        push     = '0;
        pop      = '0;
        if (grant) begin
            rr_d     = inc3(gsel);
            src_d    = gsel;
            result_d = res_mem_q[gsel][head_q[gsel]];
            tag_d    = tag_mem_q[gsel][head_q[gsel]];
`ifdef CDB_BYPASS_EN
            if (cnt_q[gsel] == '0) begin
                result_d = res_in[gsel];
                tag_d    = tag_in[gsel];
            end
`endif
        end
        for (int s = 0; s < 3; s++) begin
            pop[s]  = grant && (gsel == 2'(s)) && (cnt_q[s] != '0);
            // A full queue still accepts when it is being drained in the same cycle.
            push[s] = vld_in[s] && ((cnt_q[s] != FULL) || pop[s]);
`ifdef CDB_BYPASS_EN
            if (grant && (gsel == 2'(s)) && (cnt_q[s] == '0)) push[s] = 1'b0;
`endif
            head_d[s] = head_q[s] + PW'(pop[s]);
            tail_d[s] = tail_q[s] + PW'(push[s]);
            cnt_d[s]  = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
        end
        if (rollback_in) begin
            push     = '0;
            pop      = '0;
            rr_d     = 2'd0;
            valid_d  = 1'b0;
            result_d = result_q;
            tag_d    = tag_q;
            src_d    = src_q;
            for (int s = 0; s < 3; s++) begin
                head_d[s] = '0;
                tail_d[s] = '0;
                cnt_d[s]  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                head_q[s] <= '0;
                tail_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
            rr_q     <= 2'd0;
            valid_q  <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
            src_q    <= 2'd0;
        end else begin
            for (int s = 0; s < 3; s++) begin
                head_q[s] <= head_d[s];
                tail_q[s] <= tail_d[s];
                cnt_q[s]  <= cnt_d[s];
            end
            rr_q     <= rr_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            src_q    <= src_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (push[s]) begin
                res_mem_q[s][tail_q[s]] <= res_in[s];
                tag_mem_q[s][tail_q[s]] <= tag_in[s];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin saturation, back-pressure, rollback, full-queue wrap.
module tb_cdb_arbiter;

    localparam int TW = 4;
    localparam int DW = 32;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk, rst, rollback_in;
    logic          alu_valid_in, lsb_valid_in, rob_valid_in;
    logic [DW-1:0] alu_result_in, lsb_result_in, rob_result_in;
    logic [TW-1:0] alu_tag_in, lsb_tag_in, rob_tag_in;
    logic          alu_ready_out, lsb_ready_out, rob_ready_out;
    logic          cdb_valid_out;
    logic [DW-1:0] cdb_result_out;
    logic [TW-1:0] cdb_tag_out;
    logic [1:0]    cdb_src_out;

    int vectors     = 0;
    int miscompares = 0;
    int an, ln, rn;
    int exp_src [15] = '{-1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, -1};
    int exp_tag [15] = '{ 0, 8, 0, 4, 9, 1, 5, 10, 2, 6, 11, 3, 7, 12, 0};

    cdb_arbiter #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .rollback_in(rollback_in),
        .alu_valid_in(alu_valid_in), .alu_result_in(alu_result_in), .alu_tag_in(alu_tag_in),
        .alu_ready_out(alu_ready_out),
        .lsb_valid_in(lsb_valid_in), .lsb_result_in(lsb_result_in), .lsb_tag_in(lsb_tag_in),
        .lsb_ready_out(lsb_ready_out),
        .rob_valid_in(rob_valid_in), .rob_result_in(rob_result_in), .rob_tag_in(rob_tag_in),
        .rob_ready_out(rob_ready_out),
        .cdb_valid_out(cdb_valid_out), .cdb_result_out(cdb_result_out),
        .cdb_tag_out(cdb_tag_out), .cdb_src_out(cdb_src_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result payload encodes the source (A/B/C prefix) and the tag, so the bus value is predictable.
    task automatic drv(input bit av, input int at, input bit lv, input int lt, input bit rv, input int rt);
        alu_valid_in  = av;
        alu_tag_in    = TW'(at);
        alu_result_in = 32'hA000_0000 | 32'(at);
        lsb_valid_in  = lv;
        lsb_tag_in    = TW'(lt);
        lsb_result_in = 32'hB000_0000 | 32'(lt);
        rob_valid_in  = rv;
        rob_tag_in    = TW'(rt);
        rob_result_in = 32'hC000_0000 | 32'(rt);
    endtask

    task automatic chk_cdb(input string name, input int src, input int tag);
        if (src < 0) begin
            chk({name, "_valid"}, 64'(cdb_valid_out), 64'(0));
        end else begin
            chk({name, "_valid"}, 64'(cdb_valid_out), 64'(1));
            chk({name, "_src"}, 64'(cdb_src_out), 64'(src));
            chk({name, "_tag"}, 64'(cdb_tag_out), 64'(tag));
            chk({name, "_res"}, 64'(cdb_result_out),
                64'((32'hA000_0000 + 32'(src) * 32'h1000_0000) | 32'(tag)));
        end
    endtask

    task automatic chk_ready(input string name, input bit a, input bit l, input bit r);
        chk({name, "_alu_rdy"}, 64'(alu_ready_out), 64'(a));
        chk({name, "_lsb_rdy"}, 64'(lsb_ready_out), 64'(l));
        chk({name, "_rob_rdy"}, 64'(rob_ready_out), 64'(r));
    endtask

    initial begin
        rst = 1'b0;
        rollback_in = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 64'(cdb_valid_out), 64'(0));
        chk("rst_res", 64'(cdb_result_out), 64'(0));
        chk("rst_tag", 64'(cdb_tag_out), 64'(0));
        chk("rst_src", 64'(cdb_src_out), 64'(0));
        chk_ready("rst", 1, 1, 1);
        step();
        rst = 1'b0;

        // single ALU result, empty queues
        drv(1, 3, 0, 0, 0, 0);
        alu_result_in = 32'h0000_0042;
        step();
        chk("single_e1_valid", 64'(cdb_valid_out), 64'(BYP));
        chk("single_e1_alu_rdy", 64'(alu_ready_out), 64'(1));
        drv(0, 0, 0, 0, 0, 0);
        step();
        chk("single_e2_valid", 64'(cdb_valid_out), 64'(!BYP));
        chk("single_e2_tag", 64'(cdb_tag_out), 64'(3));
        chk("single_e2_res", 64'(cdb_result_out), 64'(32'h42));
        chk("single_e2_src", 64'(cdb_src_out), 64'(0));
        step();
        chk("single_e3_valid", 64'(cdb_valid_out), 64'(0));

        // reset with two entries queued in ALU
        drv(1, 1, 1, 9, 0, 0);
        step();
        chk_cdb("mr1", -1, 0);
        drv(1, 2, 0, 0, 0, 0);
        step();
        chk_cdb("mr2", 1, 9);
        chk_ready("mr2", 0, 1, 1);
        drv(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("mr_rst_valid", 64'(cdb_valid_out), 64'(0));
        chk("mr_rst_src", 64'(cdb_src_out), 64'(0));
        chk("mr_rst_tag", 64'(cdb_tag_out), 64'(0));
        chk("mr_rst_res", 64'(cdb_result_out), 64'(0));
        chk_ready("mr_rst", 1, 1, 1);
        #1 rst = 1'b0;
        drv(1, 5, 1, 6, 0, 0);
        step();
        chk_cdb("mr3", -1, 0);
        drv(0, 0, 0, 0, 0, 0);
        step();
        chk_cdb("mr4", 0, 5);
        step();
        chk_cdb("mr5", 1, 6);

        // saturation: every producer offers whenever it is ready, then the queues drain
        an = 0;
        ln = 4;
        rn = 8;
        for (int k = 0; k < 15; k++) begin
            if (k < 9) drv(alu_ready_out, an, lsb_ready_out, ln, rob_ready_out, rn);
            else       drv(0, 0, 0, 0, 0, 0);
            step();
            if (alu_valid_in) an++;
            if (lsb_valid_in) ln++;
            if (rob_valid_in) rn++;
            chk_cdb($sformatf("sat%0d", k), exp_src[k], exp_tag[k]);
            if (k == 1) chk_ready("sat1", 0, 0, 1);
            if (k == 2) chk_ready("sat2", 1, 0, 0);
            if (k == 3) chk_ready("sat3", 0, 1, 0);
        end

        // LSB fills while ROB and ALU take the bus
        drv(0, 0, 0, 0, 1, 13);
        step();
        chk_cdb("lf1", -1, 0);
        drv(1, 1, 1, 5, 0, 0);
        step();
        chk_cdb("lf2", 2, 13);
        drv(0, 0, 1, 6, 0, 0);
        step();
        chk_cdb("lf3", 0, 1);
        chk("lf3_lsb_rdy", 64'(lsb_ready_out), 64'(0));
        drv(0, 0, 0, 0, 0, 0);
        step();
        chk_cdb("lf4", 1, 5);
        chk("lf4_lsb_rdy", 64'(lsb_ready_out), 64'(1));
        step();
        chk_cdb("lf5", 1, 6);
        step();
        chk_cdb("lf6", -1, 0);

        // rollback with four entries queued
        drv(1, 2, 1, 7, 1, 11);
        step();
        chk_cdb("rb1", -1, 0);
        drv(1, 3, 1, 8, 0, 0);
        step();
        chk_cdb("rb2", 2, 11);
        chk_ready("rb2", 0, 0, 1);
        drv(0, 0, 0, 0, 1, 14);
        rollback_in = 1'b1;
        step();
        rollback_in = 1'b0;
        chk("rb3_valid", 64'(cdb_valid_out), 64'(0));
        chk("rb3_src", 64'(cdb_src_out), 64'(2));
        chk("rb3_tag", 64'(cdb_tag_out), 64'(11));
        chk_ready("rb3", 1, 1, 1);
        drv(0, 0, 0, 0, 0, 0);
        step();
        chk_cdb("rb4", -1, 0);
        drv(0, 0, 1, 4, 1, 9);
        step();
        chk_cdb("rb5", -1, 0);
        drv(0, 0, 0, 0, 0, 0);
        step();
        chk_cdb("rb6", 1, 4);
        step();
        chk_cdb("rb7", 2, 9);
        step();
        chk_cdb("rb8", -1, 0);

        // push and pop on a full ALU queue, pointer wrap, push while full and idle is dropped
        drv(1, 1, 0, 0, 1, 8);
        step();
        chk_cdb("fw1", -1, 0);
        drv(1, 2, 0, 0, 1, 9);
        step();
        chk_cdb("fw2", 0, 1);
        drv(1, 3, 0, 0, 0, 0);
        step();
        chk_cdb("fw3", 2, 8);
        chk("fw3_alu_rdy", 64'(alu_ready_out), 64'(0));
        drv(1, 4, 0, 0, 0, 0);
        step();
        chk_cdb("fw4", 0, 2);
        chk("fw4_alu_rdy", 64'(alu_ready_out), 64'(0));
        drv(1, 5, 0, 0, 0, 0);
        step();
        chk_cdb("fw5", 2, 9);
        chk("fw5_alu_rdy", 64'(alu_ready_out), 64'(0));
        drv(0, 0, 0, 0, 0, 0);
        step();
        chk_cdb("fw6", 0, 3);
        chk("fw6_alu_rdy", 64'(alu_ready_out), 64'(1));
        step();
        chk_cdb("fw7", 0, 4);
        step();
        chk_cdb("fw8", -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
